ristretto_fetch_unit: RTL and testbench

//  Instruction fetch unit: responder side of the prefetch-buffer/fetch-unit link in the IF stage.

---
 rtl/ristretto_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_ristretto_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ristretto_fetch_unit.sv
// ============================================================================
// Module  : ristretto_fetch_unit
// Purpose : IF-stage fetch unit; one req/gnt/rvalid transaction per fetch
//           request, owns the fetch PC. Optional error handling under
//           RISTRETTO_FU_ERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ristretto_fetch_unit #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BootAddr  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fu_fetch_i,
  output logic                 fu_busy_o,
  output logic                 fu_new_instr_o,
  output logic [DataWidth-1:0] fu_instr_o,
  output logic [AddrWidth-1:0] fu_current_pc_o,
  output logic                 fu_err_o,
  input  logic                 redirect_i,
  input  logic [AddrWidth-1:0] redirect_pc_i,
  output logic                 imem_req_o,
  output logic [AddrWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  input  logic                 imem_err_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 discard_q, discard_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic [AddrWidth-1:0] cur_pc_q, cur_pc_d;
  logic                 new_instr_q, new_instr_d;
  logic                 err_q, err_d;
  logic [AddrWidth-1:0] redirect_tgt;
  logic [DataWidth-1:0] deliver_instr;
  logic                 deliver_err;

  assign redirect_tgt = {redirect_pc_i[AddrWidth-1:2], 2'b00};

`ifdef RISTRETTO_FU_ERR_EN
  localparam logic [DataWidth-1:0] c_nop_instr = DataWidth'(32'h0000_0013);

  // A faulted fetch is replaced by a NOP so the pipeline sees a harmless word.
  assign deliver_instr = imem_err_i ? c_nop_instr : imem_rdata_i;
  assign deliver_err   = imem_err_i;
`else
  logic unused_imem_err;

  assign unused_imem_err = imem_err_i;
  assign deliver_instr   = imem_rdata_i;
  assign deliver_err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    discard_d   = discard_q;
    instr_d     = instr_q;
    cur_pc_d    = cur_pc_q;
    new_instr_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (redirect_i) begin
          pc_d = redirect_tgt;
        end else if (fu_fetch_i) begin
          state_d = S_REQ;
          addr_d  = pc_q;
        end
      end

      S_REQ: begin
        if (redirect_i) begin
          pc_d = redirect_tgt;
          if (imem_gnt_i) begin
            state_d   = S_DRAIN;
            discard_d = 1'b0;
          end else begin
            // The request must stay stable, so the stale address is still issued.
            discard_d = 1'b1;
          end
        end else if (imem_gnt_i) begin
          discard_d = 1'b0;
          if (discard_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT;
            pc_d    = pc_q + AddrWidth'(4);
          end
        end
      end

      S_WAIT: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          state_d = imem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (imem_rvalid_i) begin
          instr_d     = deliver_instr;
          err_d       = deliver_err;
          cur_pc_d    = addr_q + AddrWidth'(4);
          new_instr_d = 1'b1;
          if (fu_fetch_i) begin
            state_d = S_REQ;
            addr_d  = pc_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if (redirect_i) begin
          pc_d = redirect_tgt;
        end
        if (imem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= BootAddr;
      addr_q      <= BootAddr;
      discard_q   <= 1'b0;
      instr_q     <= '0;
      cur_pc_q    <= '0;
      new_instr_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      discard_q   <= discard_d;
      instr_q     <= instr_d;
      cur_pc_q    <= cur_pc_d;
      new_instr_q <= new_instr_d;
      err_q       <= err_d;
    end
  end

  assign fu_busy_o       = (state_q != S_IDLE);
  assign imem_req_o      = (state_q == S_REQ);
  assign imem_addr_o     = addr_q;
  assign fu_new_instr_o  = new_instr_q;
  assign fu_instr_o      = instr_q;
  assign fu_current_pc_o = cur_pc_q;
  assign fu_err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ristretto_fetch_unit.sv
// ============================================================================
// Module  : tb_ristretto_fetch_unit
// Purpose : Self-checking bench for ristretto_fetch_unit (directed + random).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ristretto_fetch_unit;

`ifdef RISTRETTO_FU_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, fetch, redirect, gnt, rvalid, err;
  logic [31:0] redirect_pc, rdata;
  logic        busy, new_instr, fu_err, req;
  logic [31:0] instr, cur_pc, addr;

  int n_checks = 0;
  int n_pass   = 0;

  ristretto_fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .fu_fetch_i(fetch), .fu_busy_o(busy),
    .fu_new_instr_o(new_instr), .fu_instr_o(instr), .fu_current_pc_o(cur_pc),
    .fu_err_o(fu_err), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch = 0; redirect = 0; redirect_pc = '0; gnt = 0; rvalid = 0; err = 0; rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    fetch = 1; rvalid = 1; rdata = 32'hFFFF_FFFF; rst = 1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || req !== 1'b0) $display("FAIL reset_busy_req: busy=%b req=%b want 0/0", busy, req); else n_pass++;
    n_checks++; if (addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", addr); else n_pass++;
    n_checks++; if (new_instr !== 1'b0 || fu_err !== 1'b0) $display("FAIL reset_pulse_err: new=%b err=%b want 0/0", new_instr, fu_err); else n_pass++;
    n_checks++; if (instr !== 32'h0 || cur_pc !== 32'h0) $display("FAIL reset_instr_pc: instr=%h pc=%h want 0/0", instr, cur_pc); else n_pass++;
    rst = 0; clear_inputs();
  endtask

  task automatic test_single_fetch();
    do_reset();
    fetch = 1; tick(); fetch = 0;
    n_checks++; if (req !== 1'b1 || addr !== 32'h0) $display("FAIL single_req: req=%b addr=%h want 1/00000000", req, addr); else n_pass++;
    gnt = 1; tick(); gnt = 0;
    n_checks++; if (req !== 1'b0 || busy !== 1'b1 || new_instr !== 1'b0) $display("FAIL single_wait: req=%b busy=%b new=%b want 0/1/0", req, busy, new_instr); else n_pass++;
    rvalid = 1; rdata = 32'h0050_0093; tick(); rvalid = 0; rdata = '0;
    n_checks++; if (new_instr !== 1'b1 || instr !== 32'h0050_0093 || cur_pc !== 32'h4 || fu_err !== 1'b0)
      $display("FAIL single_pulse: new=%b instr=%h pc=%h err=%b want 1/00500093/4/0", new_instr, instr, cur_pc, fu_err); else n_pass++;
    tick();
    n_checks++; if (new_instr !== 1'b0 || busy !== 1'b0 || instr !== 32'h0050_0093)
      $display("FAIL single_hold: new=%b busy=%b instr=%h want 0/0/00500093", new_instr, busy, instr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int grants = 0, pulses = 0, last_pulse = -10;
    bit granted = 0;
    do_reset();
    fetch = 1;
    for (int c = 0; c < 30 && pulses < 4; c++) begin
      tick();
      if (new_instr === 1'b1) begin
        n_checks++; if (c - last_pulse < 2) $display("FAIL b2b_spacing: pulse gap %0d want >=2", c - last_pulse); else n_pass++;
        n_checks++; if (cur_pc !== 32'(4 * pulses + 4) || instr !== 32'hA000_0000 + 32'(pulses))
          $display("FAIL b2b_pulse%0d: pc=%h instr=%h want %h/%h", pulses, cur_pc, instr, 32'(4 * pulses + 4), 32'hA000_0000 + 32'(pulses)); else n_pass++;
        last_pulse = c; pulses++;
      end
      rvalid = granted; rdata = 32'hA000_0000 + 32'(grants - 1); granted = 0;
      gnt = 0;
      if (req === 1'b1 && grants < 4) begin
        n_checks++; if (addr !== 32'(4 * grants)) $display("FAIL b2b_addr%0d: got %h want %h", grants, addr, 32'(4 * grants)); else n_pass++;
        gnt = 1; granted = 1; grants++;
        if (grants == 4) fetch = 0;
      end
    end
    clear_inputs();
    n_checks++; if (pulses != 4) $display("FAIL b2b_count: got %0d pulses want 4", pulses); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || req !== 1'b0) $display("FAIL b2b_idle: busy=%b req=%b want 0/0", busy, req); else n_pass++;
  endtask

  // Runs after back-to-back: fetch PC is 0x10.
  task automatic test_gnt_delay();
    fetch = 1; tick(); fetch = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (req !== 1'b1 || addr !== 32'h10 || busy !== 1'b1)
        $display("FAIL gnt_delay_stable%0d: req=%b addr=%h busy=%b want 1/00000010/1", i, req, addr, busy); else n_pass++;
      tick();
    end
    gnt = 1; tick(); gnt = 0;
    rvalid = 1; rdata = 32'h1234_5678; tick(); rvalid = 0;
    n_checks++; if (new_instr !== 1'b1 || cur_pc !== 32'h14 || instr !== 32'h1234_5678)
      $display("FAIL gnt_delay_pulse: new=%b pc=%h instr=%h want 1/00000014/12345678", new_instr, cur_pc, instr); else n_pass++;
    tick();
  endtask

  task automatic test_redirect_wait();
    fetch = 1; tick(); fetch = 0;
    n_checks++; if (req !== 1'b1 || addr !== 32'h14) $display("FAIL rdw_req: req=%b addr=%h want 1/00000014", req, addr); else n_pass++;
    gnt = 1; tick(); gnt = 0;
    redirect = 1; redirect_pc = 32'h0000_0102; tick(); redirect = 0;
    n_checks++; if (busy !== 1'b1 || req !== 1'b0) $display("FAIL rdw_drain: busy=%b req=%b want 1/0", busy, req); else n_pass++;
    rvalid = 1; rdata = 32'hDEAD_0001; tick(); rvalid = 0;
    n_checks++; if (new_instr !== 1'b0 || instr !== 32'h1234_5678 || busy !== 1'b0)
      $display("FAIL rdw_dropped: new=%b instr=%h busy=%b want 0/12345678/0", new_instr, instr, busy); else n_pass++;
    fetch = 1; tick(); fetch = 0;
    n_checks++; if (req !== 1'b1 || addr !== 32'h100) $display("FAIL rdw_target: req=%b addr=%h want 1/00000100", req, addr); else n_pass++;
    gnt = 1; tick(); gnt = 0;
    rvalid = 1; rdata = 32'h0000_0513; tick(); rvalid = 0;
    n_checks++; if (new_instr !== 1'b1 || cur_pc !== 32'h104 || instr !== 32'h0000_0513)
      $display("FAIL rdw_pulse: new=%b pc=%h instr=%h want 1/00000104/00000513", new_instr, cur_pc, instr); else n_pass++;
    tick();
  endtask

  task automatic test_redirect_req();
    fetch = 1; tick(); fetch = 0;
    redirect = 1; redirect_pc = 32'h0000_0203; tick(); redirect = 0;
    n_checks++; if (req !== 1'b1 || addr !== 32'h104) $display("FAIL rdr_stable: req=%b addr=%h want 1/00000104", req, addr); else n_pass++;
    tick();
    gnt = 1; tick(); gnt = 0;
    n_checks++; if (req !== 1'b0 || busy !== 1'b1) $display("FAIL rdr_drain: req=%b busy=%b want 0/1", req, busy); else n_pass++;
    rvalid = 1; rdata = 32'hDEAD_0002; tick(); rvalid = 0;
    n_checks++; if (new_instr !== 1'b0 || busy !== 1'b0) $display("FAIL rdr_dropped: new=%b busy=%b want 0/0", new_instr, busy); else n_pass++;
    fetch = 1; tick(); fetch = 0;
    n_checks++; if (req !== 1'b1 || addr !== 32'h200) $display("FAIL rdr_target: req=%b addr=%h want 1/00000200", req, addr); else n_pass++;
    gnt = 1; tick(); gnt = 0;
    rvalid = 1; rdata = 32'h0011_0113; tick(); rvalid = 0;
    n_checks++; if (new_instr !== 1'b1 || cur_pc !== 32'h204) $display("FAIL rdr_pulse: new=%b pc=%h want 1/00000204", new_instr, cur_pc); else n_pass++;
    tick();
  endtask

  task automatic test_error();
    logic [31:0] exp_instr;
    exp_instr = ERR_EN ? NOP : 32'hDEAD_BEEF;
    fetch = 1; tick(); fetch = 0;
    gnt = 1; tick(); gnt = 0;
    rvalid = 1; err = 1; rdata = 32'hDEAD_BEEF; tick(); rvalid = 0; err = 0;
    n_checks++; if (new_instr !== 1'b1 || instr !== exp_instr || fu_err !== ERR_EN)
      $display("FAIL err_pulse: new=%b instr=%h err=%b want 1/%h/%b", new_instr, instr, fu_err, exp_instr, ERR_EN); else n_pass++;
    tick();
    n_checks++; if (fu_err !== 1'b0 || new_instr !== 1'b0) $display("FAIL err_clear: err=%b new=%b want 0/0", fu_err, new_instr); else n_pass++;
  endtask

  // Transaction-level reference: a pending request, an outstanding response,
  // each marked live or killed by a redirect; the PC advances on live grants.
  task automatic test_random();
    logic [31:0] m_next_pc, m_pend_addr, m_out_addr, m_instr, m_cpc;
    bit m_pending, m_pend_live, m_out, m_out_live, m_pulse, m_err, start;
    do_reset();
    m_next_pc = 0; m_pend_addr = 0; m_out_addr = 0; m_instr = 0; m_cpc = 0;
    m_pending = 0; m_pend_live = 0; m_out = 0; m_out_live = 0; m_pulse = 0; m_err = 0;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      fetch       = $urandom_range(0, 1) == 1;
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom;
      gnt         = m_pending && ($urandom_range(0, 2) != 0);
      rvalid      = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      rdata       = $urandom;
      err         = ($urandom_range(0, 3) == 0);
      m_pulse = 0; m_err = 0; start = 0;
      if (rst) begin
        m_next_pc = 0; m_pending = 0; m_out = 0; m_instr = 0; m_cpc = 0;
      end else begin
        if (m_pending) begin
          if (gnt) begin
            m_pending = 0; m_out = 1; m_out_addr = m_pend_addr;
            m_out_live = m_pend_live && !redirect;
            if (m_out_live) m_next_pc = m_next_pc + 4;
          end else if (redirect) begin
            m_pend_live = 0;
          end
        end else if (m_out) begin
          if (rvalid) begin
            m_out = 0;
            if (m_out_live && !redirect) begin
              m_pulse = 1; m_err = ERR_EN && err;
              m_instr = m_err ? NOP : rdata;
              m_cpc   = m_out_addr + 4;
              start   = fetch;
            end
          end else if (redirect) begin
            m_out_live = 0;
          end
        end else begin
          start = fetch && !redirect;
        end
        if (start) begin
          m_pending = 1; m_pend_live = 1; m_pend_addr = m_next_pc;
        end
        if (redirect) m_next_pc = redirect_pc & ~32'h3;
      end
      tick();
      n_checks++; if (req !== m_pending) $display("FAIL rnd_req@%0d: got %b want %b", c, req, m_pending); else n_pass++;
      if (m_pending) begin
        n_checks++; if (addr !== m_pend_addr) $display("FAIL rnd_addr@%0d: got %h want %h", c, addr, m_pend_addr); else n_pass++;
      end
      n_checks++; if (busy !== (m_pending || m_out)) $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, m_pending || m_out); else n_pass++;
      n_checks++; if (new_instr !== m_pulse) $display("FAIL rnd_pulse@%0d: got %b want %b", c, new_instr, m_pulse); else n_pass++;
      n_checks++; if (instr !== m_instr || cur_pc !== m_cpc || fu_err !== m_err)
        $display("FAIL rnd_data@%0d: instr=%h pc=%h err=%b want %h/%h/%b", c, instr, cur_pc, fu_err, m_instr, m_cpc, m_err); else n_pass++;
    end
    rst = 0; clear_inputs();
  endtask

  initial begin
    rst = 1; clear_inputs();
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_gnt_delay();
    test_redirect_wait();
    test_redirect_req();
    test_error();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
